// File: rtl/bsg_store_and_forward_arb_if.sv
// Requester-side and buffer-side beat handshake for the packet-atomic
// arbiter in front of a store-and-forward buffer.
interface bsg_store_and_forward_arb_if #(
  parameter int width_p = 32,
  parameter int els_p   = 4
);
  logic [els_p*width_p-1:0] data_i;
  logic [els_p-1:0]         v_i;
  logic [els_p-1:0]         last_i;
  logic [els_p-1:0]         error_i;
  logic [els_p-1:0]         ready_o;
  logic [width_p-1:0]       data_o;
  logic                     v_o;
  logic                     last_o;
  logic                     error_o;
  logic                     ready_i;

  modport slave (
    input  data_i, v_i, last_i, error_i, ready_i,
    output ready_o, data_o, v_o, last_o, error_o
  );

  modport master (
    output data_i, v_i, last_i, error_i, ready_i,
    input  ready_o, data_o, v_o, last_o, error_o
  );
endinterface

// File: rtl/bsg_store_and_forward_arb.sv
// Packet-atomic round-robin arbiter sharing one store-and-forward buffer,
// with delayed packet-status attribution and per-requester saturating counts.
//
//   state  | meaning
//   idle_s | no packet open; round-robin grant from rr_q, zero latency
//   busy_s | packet open; grant locked to owner_q until its last beat moves
module bsg_store_and_forward_arb #(
  parameter  int width_p       = 32,
  parameter  int els_p         = 4,
  parameter  int count_width_p = 16,
  localparam int id_width_lp   = $clog2(els_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  bsg_store_and_forward_arb_if.slave       bus_if,
  input  logic                             good_packet_i,
  input  logic                             incomplete_packet_i,
  input  logic                             bad_packet_i,
  output logic                             stat_v_o,
  output logic [id_width_lp-1:0]           stat_id_o,
  output logic [1:0]                       stat_code_o,
  output logic [els_p*count_width_p-1:0]   good_count_o,
  output logic [els_p*count_width_p-1:0]   drop_count_o,
  input  logic                             clr_i
);

  typedef enum logic {idle_s, busy_s} state_e;

  state_e                   state_q;
  logic [id_width_lp-1:0]   owner_q, rr_q, pend_id_q;
  logic                     pend_v_q;
  logic [id_width_lp-1:0]   gnt_id, rr_d;
  logic                     gnt_found, xfer, xfer_last;
  logic [els_p-1:0]         grant;
  logic [count_width_p-1:0] good_q [els_p];
  logic [count_width_p-1:0] drop_q [els_p];

  always_comb begin
    gnt_id    = rr_q;
    gnt_found = 1'b0;
    if (state_q == busy_s) begin
      gnt_id    = owner_q;
      gnt_found = 1'b1;
    end else begin
      for (int k = 0; k < els_p; k++) begin
        if (!gnt_found && bus_if.v_i[(int'(rr_q) + k) % els_p]) begin
          gnt_found = 1'b1;
          gnt_id    = id_width_lp'((int'(rr_q) + k) % els_p);
        end
      end
    end
    grant         = '0;
    grant[gnt_id] = gnt_found;
  end

  assign bus_if.v_o     = gnt_found & bus_if.v_i[gnt_id];
  assign bus_if.data_o  = bus_if.data_i[gnt_id*width_p +: width_p];
  assign bus_if.last_o  = bus_if.last_i[gnt_id];
  assign bus_if.error_o = bus_if.error_i[gnt_id];
  assign bus_if.ready_o = bus_if.ready_i ? grant : '0;

  assign xfer      = bus_if.v_o & bus_if.ready_i;
  assign xfer_last = xfer & bus_if.last_o;
  assign rr_d      = (gnt_id == id_width_lp'(els_p - 1)) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= idle_s;
      owner_q   <= '0;
      rr_q      <= '0;
      pend_v_q  <= 1'b0;
      pend_id_q <= '0;
    end else begin
      pend_v_q <= xfer_last;
      if (xfer_last) pend_id_q <= gnt_id;
      case (state_q)
        idle_s: if (xfer_last) begin
          rr_q <= rr_d;
        end else if (xfer) begin
          state_q <= busy_s;
          owner_q <= gnt_id;
        end
        busy_s: if (xfer_last) begin
          state_q <= idle_s;
          rr_q    <= rr_d;
        end
        default: state_q <= idle_s;
      endcase
    end
  end

  // Status arriving without a pending last beat has no owner and is dropped.
  assign stat_v_o    = pend_v_q & (good_packet_i | incomplete_packet_i | bad_packet_i);
  assign stat_id_o   = pend_id_q;
  assign stat_code_o = incomplete_packet_i ? 2'd1 : (bad_packet_i ? 2'd2 : 2'd0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) begin
        good_q[i] <= '0;
        drop_q[i] <= '0;
      end
    end else if (clr_i) begin
      for (int i = 0; i < els_p; i++) begin
        good_q[i] <= '0;
        drop_q[i] <= '0;
      end
    end else if (stat_v_o) begin
      for (int i = 0; i < els_p; i++) begin
        if (stat_id_o == id_width_lp'(i)) begin
          if (stat_code_o == 2'd0) begin
            if (good_q[i] != '1) good_q[i] <= good_q[i] + 1'b1;
          end else begin
            if (drop_q[i] != '1) drop_q[i] <= drop_q[i] + 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < els_p; g++) begin : g_cnt
    assign good_count_o[g*count_width_p +: count_width_p] = good_q[g];
    assign drop_count_o[g*count_width_p +: count_width_p] = drop_q[g];
  end

  a_grant_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    $onehot0(grant));
  a_owner_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (state_q == busy_s && !xfer_last) |=> (state_q == busy_s && owner_q == $past(owner_q)));
  a_status_single: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    pend_v_q |-> $onehot0({good_packet_i, incomplete_packet_i, bad_packet_i}));

endmodule

// File: tb/tb_bsg_store_and_forward_arb.sv
// Directed bench for bsg_store_and_forward_arb: round-robin order, packet
// atomicity, backpressure, status attribution, counter saturation and reset.
module tb_bsg_store_and_forward_arb;
  logic       clk_i = 1'b0;
  logic       reset_n_i;
  logic       good_packet_i, incomplete_packet_i, bad_packet_i, clr_i;
  logic       stat_v_o;
  logic [1:0] stat_id_o, stat_code_o;
  logic [7:0] good_count_o, drop_count_o;
  int         checks = 0;
  int         errors = 0;
  int         beats;
  logic [3:0] exp4;

  always #5 clk_i = ~clk_i;

  bsg_store_and_forward_arb_if #(.width_p(8), .els_p(4)) bus_if ();

  bsg_store_and_forward_arb #(.width_p(8), .els_p(4), .count_width_p(2)) dut (
    .clk_i               (clk_i),
    .reset_n_i           (reset_n_i),
    .bus_if              (bus_if),
    .good_packet_i       (good_packet_i),
    .incomplete_packet_i (incomplete_packet_i),
    .bad_packet_i        (bad_packet_i),
    .stat_v_o            (stat_v_o),
    .stat_id_o           (stat_id_o),
    .stat_code_o         (stat_code_o),
    .good_count_o        (good_count_o),
    .drop_count_o        (drop_count_o),
    .clr_i               (clr_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    reset_n_i = 1'b0;
    good_packet_i = 1'b0; incomplete_packet_i = 1'b0; bad_packet_i = 1'b0; clr_i = 1'b0;
    bus_if.data_i  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus_if.v_i     = 4'b0000;
    bus_if.last_i  = 4'b0000;
    bus_if.error_i = 4'b1000;
    bus_if.ready_i = 1'b0;
    repeat (2) cyc();
    check("rst_v_o", bus_if.v_o, 1'b0);
    check("rst_ready_o", bus_if.ready_o, 4'b0000);
    check("rst_stat_v", stat_v_o, 1'b0);
    check("rst_good", good_count_o, 8'h00);
    check("rst_drop", drop_count_o, 8'h00);
    reset_n_i = 1'b1;
    cyc();

    // all four send single-beat packets: 0,1,2,3,0 one per cycle
    bus_if.v_i = 4'b1111; bus_if.last_i = 4'b1111; bus_if.ready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #2;
      exp4 = 4'b0001 << (k % 4);
      check("t1_ready", bus_if.ready_o, exp4);
      check("t1_data", bus_if.data_o, 8'hA0 + 8'(k % 4));
      cyc();
    end

    // req1 three-beat packet holds off req2 (rr now 1)
    bus_if.v_i = 4'b0010; bus_if.last_i = 4'b0000; #2;
    check("t2_first", bus_if.ready_o, 4'b0010);
    cyc();
    bus_if.v_i = 4'b0110; bus_if.last_i = 4'b0100; #2;
    check("t2_mid_ready", bus_if.ready_o, 4'b0010);
    check("t2_mid_last", bus_if.last_o, 1'b0);
    check("t2_mid_data", bus_if.data_o, 8'hA1);
    cyc();
    bus_if.last_i = 4'b0110; #2;
    check("t2_last_ready", bus_if.ready_o, 4'b0010);
    check("t2_last_flag", bus_if.last_o, 1'b1);
    cyc();
    bus_if.v_i = 4'b0100; bus_if.last_i = 4'b0100; good_packet_i = 1'b1; #2;
    check("t2_req2", bus_if.ready_o, 4'b0100);
    check("t2_stat_v", stat_v_o, 1'b1);
    check("t2_stat_id", stat_id_o, 2'd1);
    check("t2_stat_code", stat_code_o, 2'd0);
    cyc();
    bus_if.v_i = 4'b0000; good_packet_i = 1'b0; #2;
    check("t2_good_cnt", good_count_o, 8'h04);
    check("t2_no_status", stat_v_o, 1'b0);
    cyc();

    // req0 four-beat packet under 1010 backpressure, req1 kept waiting (rr now 3)
    beats = 0;
    for (int c = 0; c < 7; c++) begin
      bus_if.ready_i = (c % 2 == 0);
      bus_if.v_i     = 4'b0011;
      bus_if.last_i  = (c == 6) ? 4'b0011 : 4'b0010;
      #2;
      exp4 = bus_if.ready_i ? 4'b0001 : 4'b0000;
      check("t3_ready", bus_if.ready_o, exp4);
      check("t3_v_o", bus_if.v_o, 1'b1);
      if (bus_if.v_o && bus_if.ready_i) beats++;
      cyc();
    end
    bus_if.ready_i = 1'b0; bus_if.v_i = 4'b0000; #2;
    check("t3_beats", beats, 4);
    cyc();
    bus_if.ready_i = 1'b1; bus_if.v_i = 4'b0010; bus_if.last_i = 4'b0010; #2;
    check("t3_next_rr", bus_if.ready_o, 4'b0010);
    cyc();

    // req3 single-beat packet reported bad (rr now 2)
    bus_if.v_i = 4'b1000; bus_if.last_i = 4'b1000; #2;
    check("t4_ready", bus_if.ready_o, 4'b1000);
    check("t4_error_o", bus_if.error_o, 1'b1);
    cyc();
    bus_if.v_i = 4'b0000; bus_if.last_i = 4'b0000; bad_packet_i = 1'b1; #2;
    check("t4_stat_v", stat_v_o, 1'b1);
    check("t4_stat_id", stat_id_o, 2'd3);
    check("t4_stat_code", stat_code_o, 2'd2);
    cyc();
    bad_packet_i = 1'b0; good_packet_i = 1'b1; #2;
    check("t4_drop_cnt", drop_count_o, 8'h40);
    check("t4_orphan_status", stat_v_o, 1'b0);
    cyc();
    good_packet_i = 1'b0; #2;
    check("t4_good_unchanged", good_count_o, 8'h04);

    // five good packets from req0 saturate a 2-bit counter (rr now 0)
    for (int k = 0; k < 6; k++) begin
      bus_if.v_i    = (k < 5) ? 4'b0001 : 4'b0000;
      bus_if.last_i = bus_if.v_i;
      good_packet_i = (k >= 1);
      #2;
      if (k < 5) check("t5_ready", bus_if.ready_o, 4'b0001);
      cyc();
    end
    good_packet_i = 1'b0; #2;
    check("t5_saturate", good_count_o, 8'h07);
    bus_if.v_i = 4'b0100; bus_if.last_i = 4'b0100; #2;
    check("t5_req2", bus_if.ready_o, 4'b0100);
    cyc();
    bus_if.v_i = 4'b0000; incomplete_packet_i = 1'b1; #2;
    check("t5_inc_code", stat_code_o, 2'd1);
    check("t5_inc_id", stat_id_o, 2'd2);
    cyc();
    incomplete_packet_i = 1'b0; #2;
    check("t5_drop_cnt", drop_count_o, 8'h50);
    bus_if.v_i = 4'b0001; bus_if.last_i = 4'b0001; #2;
    check("t5_req0", bus_if.ready_o, 4'b0001);
    cyc();
    bus_if.v_i = 4'b0000; good_packet_i = 1'b1; clr_i = 1'b1; #2;
    check("t5_clr_stat_v", stat_v_o, 1'b1);
    cyc();
    good_packet_i = 1'b0; clr_i = 1'b0; #2;
    check("t5_clr_good", good_count_o, 8'h00);
    check("t5_clr_drop", drop_count_o, 8'h00);

    // reset in the middle of a req2 packet (rr now 1)
    bus_if.v_i = 4'b0010; bus_if.last_i = 4'b0010; #2;
    cyc();
    bus_if.v_i = 4'b0100; bus_if.last_i = 4'b0000; good_packet_i = 1'b1; #2;
    check("t6_req2_first", bus_if.ready_o, 4'b0100);
    check("t6_stat_id", stat_id_o, 2'd1);
    cyc();
    bus_if.v_i = 4'b0101; good_packet_i = 1'b0; #2;
    check("t6_busy_hold", bus_if.ready_o, 4'b0100);
    check("t6_good_cnt", good_count_o, 8'h04);
    reset_n_i = 1'b0; bus_if.v_i = 4'b0000; #2;
    check("t6_rst_good", good_count_o, 8'h00);
    check("t6_rst_stat_v", stat_v_o, 1'b0);
    check("t6_rst_v_o", bus_if.v_o, 1'b0);
    cyc();
    reset_n_i = 1'b1;
    bus_if.v_i = 4'b0101; bus_if.last_i = 4'b0101; #2;
    check("t6_idle_rr0", bus_if.ready_o, 4'b0001);
    check("t6_data", bus_if.data_o, 8'hA0);
    cyc();
    bus_if.v_i = 4'b0000;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
